// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the Y86 instruction memory loader and the fetch stage
// that consumes its read port.
package instr_mem_loader_pkg;

  localparam int FETCH_BYTES = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    OVFL  = 2'd3
  } load_state_t;

  typedef enum logic [1:0] {
    AOK = 2'd0,
    HLT = 2'd1,
    ADR = 2'd2,
    INS = 2'd3
  } fetch_stat_t;

  // Fetch folds the loader's address error into its status code.
  function automatic fetch_stat_t fetch_status(input logic addr_err);
    return addr_err ? ADR : AOK;
  endfunction

endpackage

// File: rtl/instr_mem_loader_imem_array.sv
// Byte-wide instruction RAM: one synchronous write port and FETCH_BYTES
// independent combinational read lanes. Contents are never reset.
module imem_array #(
  parameter  int MEM_BYTES   = 1024,
  parameter  int FETCH_BYTES = 10,
  localparam int AW          = $clog2(MEM_BYTES)
) (
  input  logic                      i_clk,
  input  logic                      i_wr_en,
  input  logic [AW-1:0]             i_wr_addr,
  input  logic [7:0]                i_wr_data,
  input  logic [FETCH_BYTES*AW-1:0] i_rd_addr,
  output logic [8*FETCH_BYTES-1:0]  o_rd_data
);
  import instr_mem_loader_pkg::*;

  logic [7:0] r_mem [MEM_BYTES];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      o_rd_data[8*i +: 8] = r_mem[i_rd_addr[AW*i +: AW]];
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a Y86 program into instruction memory, then serves FETCH_BYTES-wide
// fetch reads with one cycle of latency and halt-byte masking past the program.
module instr_mem_loader #(
  parameter int MEM_BYTES   = 1024,
  parameter int FETCH_BYTES = instr_mem_loader_pkg::FETCH_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ld_start,
  input  logic                       ld_valid,
  input  logic [7:0]                 ld_data,
  input  logic                       ld_last,
  output logic                       ld_ready,
  output logic                       ld_done,
  output logic                       ld_overflow,
  output logic [$clog2(MEM_BYTES):0] ld_len,
  input  logic [63:0]                rd_pc,
  output logic [8*FETCH_BYTES-1:0]   rd_bytes,
  output logic                       rd_valid,
  output logic                       rd_err
);
  import instr_mem_loader_pkg::*;

  localparam int AW = $clog2(MEM_BYTES);
  localparam int LW = AW + 1;

  load_state_t              r_state;
  logic [LW-1:0]            r_len;
  logic                     r_ready;
  logic                     r_done;
  logic                     r_ovf;
  logic [8*FETCH_BYTES-1:0] r_rd_bytes;
  logic                     r_rd_valid;
  logic                     r_rd_err;

  logic                      w_full;
  logic                      w_wr_en;
  logic [64:0]               w_lane;
  logic [FETCH_BYTES-1:0]    w_lane_ok;
  logic [FETCH_BYTES*AW-1:0] w_rd_addr;
  logic [8*FETCH_BYTES-1:0]  w_raw;
  logic [8*FETCH_BYTES-1:0]  w_masked;

  // MEM_BYTES is a power of two, so the top length bit means "memory full".
  assign w_full  = r_len[AW];
  assign w_wr_en = (r_state == LOAD) && ld_valid && !ld_start && !w_full;

  imem_array #(
    .MEM_BYTES  (MEM_BYTES),
    .FETCH_BYTES(FETCH_BYTES)
  ) u_imem_array (
    .i_clk    (clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_len[AW-1:0]),
    .i_wr_data(ld_data),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_start) begin
            r_state <= LOAD;
            r_len   <= '0;
            r_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_start) begin
            r_len <= '0;
          end else if (ld_valid) begin
            if (w_full) begin
              r_state <= OVFL;
              r_ovf   <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_len <= r_len + LW'(1);
              if (ld_last) begin
                r_state <= READY;
                r_done  <= 1'b1;
                r_ready <= 1'b0;
              end
            end
          end
        end
        default: begin
          if (ld_start) begin
            r_state <= LOAD;
            r_len   <= '0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  // Lane sums are 65 bits wide so a pc near 2^64-1 cannot wrap back to 0.
  always_comb begin
    w_rd_addr = '0;
    w_lane_ok = '0;
    w_lane    = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      w_lane                = {1'b0, rd_pc} + 65'(i);
      w_rd_addr[AW*i +: AW] = w_lane[AW-1:0];
      w_lane_ok[i]          = (w_lane < 65'(r_len));
    end
  end

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < FETCH_BYTES; i++) begin
      if (w_lane_ok[i]) begin
        w_masked[8*i +: 8] = w_raw[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_bytes <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == READY);
      r_rd_err   <= (rd_pc >= 64'(MEM_BYTES));
      r_rd_bytes <= (r_state == READY) ? w_masked : '0;
    end
  end

  assign ld_ready    = r_ready;
  assign ld_done     = r_done;
  assign ld_overflow = r_ovf;
  assign ld_len      = r_len;
  assign rd_bytes    = r_rd_bytes;
  assign rd_valid    = r_rd_valid;
  assign rd_err      = r_rd_err;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter MEM_BYTES, default 1024: instruction memory size in bytes; must be a power of two and at least 16.
REQ-002 Parameter FETCH_BYTES, default 10: bytes returned per fetch read, which is the longest Y86 instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ld_start  input  1  one-cycle pulse that begins a program load and clears the loaded length.
REQ-006 ld_valid  input  1  a program byte is present on ld_data.
REQ-007 ld_data  input  8  program byte; bytes arrive in ascending address order from address 0.
REQ-008 ld_last  input  1  qualifies the final byte of the load when sampled with ld_valid.
REQ-009 ld_ready  output  1  the block accepts a byte this cycle when ld_valid and ld_ready are both high.
REQ-010 ld_done  output  1  a load completed successfully and the read port is enabled.
REQ-011 ld_overflow  output  1  the load exceeded MEM_BYTES; sticky until the next ld_start or reset.
REQ-012 ld_len  output  clog2(MEM_BYTES)+1  number of bytes accepted by the current or last load.
REQ-013 rd_pc  input  64  fetch address driven by the fetch stage.
REQ-014 rd_bytes  output  8*FETCH_BYTES  bytes at rd_pc..rd_pc+FETCH_BYTES-1; the byte at rd_pc sits at bits [7:0].
REQ-015 rd_valid  output  1  rd_bytes and rd_err correspond to the rd_pc sampled one cycle earlier.
REQ-016 rd_err  output  1  the sampled rd_pc was at or above MEM_BYTES; maps to the fetch stage's address-error status.

Function
REQ-017 The FSM states shall be IDLE, LOAD, READY and OVFL.
REQ-018 IDLE -> LOAD shall occur on ld_start, and ld_len shall clear to 0.
REQ-019 In LOAD, ld_ready shall be 1, and each handshake shall write ld_data to mem[ld_len] and increment ld_len.
REQ-020 LOAD -> READY shall occur on a handshake with ld_last=1; ld_done shall assert in the next cycle.
REQ-021 A handshake in LOAD with ld_len==MEM_BYTES shall not write memory and shall go to OVFL with ld_overflow=1 and ld_ready=0.
REQ-022 A handshake that writes the last location (ld_len==MEM_BYTES-1) with ld_last=1 shall go to READY and is not an overflow.
REQ-023 ld_start in READY or OVFL shall go to LOAD, clear ld_len, ld_done and ld_overflow, and leave memory contents untouched.
REQ-024 ld_start in LOAD shall restart the load with ld_len=0; a handshake in the same cycle shall be dropped.
REQ-025 ld_valid outside LOAD shall be ignored, and ld_ready shall be 0 there.
REQ-026 The read port shall have a 1-cycle latency: rd_pc is registered and rd_bytes, rd_valid and rd_err are valid in the following cycle.
REQ-027 rd_valid shall be 1 only when the state was READY in the cycle rd_pc was sampled; otherwise it is 0, and rd_bytes shall then be 0.
REQ-028 Any byte whose address is at or above ld_len or at or above MEM_BYTES shall read as 8'h00 (halt); there is no wrap-around.
REQ-029 rd_err shall be 1 when rd_pc >= MEM_BYTES, comparing the full 64 bits so that upper-bit aliasing cannot occur.
REQ-030 Address arithmetic rd_pc+i (i < FETCH_BYTES) shall use 65-bit width so that overflow past 2^64-1 reads 8'h00.

Reset
REQ-031 While reset=0, the state shall be IDLE, ld_len=0 and ld_done=0.
REQ-032 While reset=0, ld_overflow, ld_ready, rd_valid and rd_err shall be 0, and rd_bytes shall be 0.
REQ-033 Memory array contents shall not be reset; REQ-028 masks unloaded bytes.
REQ-034 Reset asserted mid-load shall abort the load immediately; bytes already written persist but are masked because ld_len=0.

Structure
REQ-035 A shared package shall hold the FSM state encoding, FETCH_BYTES, and the 2-bit status codes AOK, HLT, ADR and INS used by fetch.
REQ-036 One sub-module, imem_array, shall hold the byte RAM: one write port, FETCH_BYTES combinational read lanes, and no reset.

Verification
REQ-037 Load 3 bytes 30 F2 0A with ld_last on the third, then read rd_pc=0 -> ld_done=1, ld_len=3, and the next cycle gives rd_bytes[23:0]=0AF230 with the upper 7 bytes 00, rd_valid=1 and rd_err=0.
REQ-038 Load MEM_BYTES+1 bytes with no ld_last -> ld_overflow=1 after the final handshake, ld_ready=0, ld_len=MEM_BYTES and ld_done=0.
REQ-039 Read rd_pc=MEM_BYTES-4 after a full load -> the 4 low bytes match memory, the 6 upper bytes are 00 and rd_err=0; read rd_pc=MEM_BYTES -> rd_err=1 and rd_bytes=0.
REQ-040 Drop reset low after 5 bytes of a load -> all outputs reach reset values in the same cycle; then ld_start and 2 bytes -> reads at addresses 2 to 4 return 00.
REQ-041 Pulse ld_start with ld_valid in the same LOAD cycle -> the byte is dropped and ld_len=0.
REQ-042 Read rd_pc=64'hFFFF_FFFF_FFFF_FFFA -> rd_err=1, rd_bytes=0 and no simulation X values.
